// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared playfield geometry, tile code constants, FSM state
//               encoding and the game-state snapshot record used by the
//               frame serializer and any downstream tile consumer.
// Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Playfield geometry (columns x rows)
    localparam int GRID_W = 20;
    localparam int GRID_H = 15;

    localparam int NUM_ENEMIES = 3;

    // Tile codes carried on tile_code
    localparam logic [2:0] TILE_EMPTY  = 3'd0;
    localparam logic [2:0] TILE_PLAYER = 3'd1;
    localparam logic [2:0] TILE_BULLET = 3'd2;
    localparam logic [2:0] TILE_ENEMY  = 3'd3;
    localparam logic [2:0] TILE_HIT    = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Game state frozen at frame_start; every tile of a frame is
    // classified against this copy only.
    typedef struct packed {
        logic [4:0]                  player_x;
        logic [3:0]                  player_y;
        logic [4:0]                  bullet_x;
        logic [3:0]                  bullet_y;
        logic                        bullet_active;
        logic [NUM_ENEMIES-1:0][4:0] enemy_x;
        logic [NUM_ENEMIES-1:0][3:0] enemy_y;
        logic [NUM_ENEMIES-1:0]      enemy_active;
    } snapshot_t;

    // An object occupies (col,row) only when it is active and its own
    // coordinate lies inside the playfield; off-field objects never match.
    function automatic logic cell_match(
        input logic [4:0] obj_x,
        input logic [3:0] obj_y,
        input logic       obj_active,
        input logic [4:0] col,
        input logic [3:0] row,
        input logic [4:0] col_max,
        input logic [3:0] row_max
    );
        return obj_active && (obj_x <= col_max) && (obj_y <= row_max) &&
               (obj_x == col) && (obj_y == row);
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/tile_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tile_classifier
// Description : Combinational tile code for one playfield cell, derived from
//               the frozen game-state snapshot.
//   Ports:
//     col       in   5   cell column
//     row       in   4   cell row
//     snap      in   --  game-state snapshot
//     tile_code out  3   EMPTY/PLAYER/BULLET/ENEMY/HIT
// Revision    : 1.0  initial release
// ============================================================================
module tile_classifier
    import game_pkg::*;
#(
    parameter int GRID_W = game_pkg::GRID_W,
    parameter int GRID_H = game_pkg::GRID_H
) (
    input  logic [4:0] col,
    input  logic [3:0] row,
    input  snapshot_t  snap,
    output logic [2:0] tile_code
);

    localparam logic [4:0] c_COL_MAX = 5'(GRID_W - 1);
    localparam logic [3:0] c_ROW_MAX = 4'(GRID_H - 1);

    logic                   w_player_hit;
    logic                   w_bullet_hit;
    logic [NUM_ENEMIES-1:0] w_enemy_hit;

    // The player has no valid flag: it is always present on the field.
    assign w_player_hit = cell_match(snap.player_x, snap.player_y, 1'b1,
                                     col, row, c_COL_MAX, c_ROW_MAX);
    assign w_bullet_hit = cell_match(snap.bullet_x, snap.bullet_y, snap.bullet_active,
                                     col, row, c_COL_MAX, c_ROW_MAX);

    generate
        for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_enemy
            assign w_enemy_hit[gi] = cell_match(snap.enemy_x[gi], snap.enemy_y[gi],
                                                snap.enemy_active[gi],
                                                col, row, c_COL_MAX, c_ROW_MAX);
        end
    endgenerate

    // Player outranks everything; a bullet sharing a cell with any enemy
    // is reported as a hit rather than as either object alone.
    always_comb begin
        tile_code = TILE_EMPTY;
        if (w_player_hit) begin
            tile_code = TILE_PLAYER;
        end else if (w_bullet_hit && (|w_enemy_hit)) begin
            tile_code = TILE_HIT;
        end else if (w_bullet_hit) begin
            tile_code = TILE_BULLET;
        end else if (|w_enemy_hit) begin
            tile_code = TILE_ENEMY;
        end
    end

endmodule : tile_classifier
`default_nettype wire

// File: rtl/game_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : game_frame_serializer
// Description : On frame_start, freezes the game state and streams one tile
//               word per playfield cell in row-major order over a
//               valid/ready handshake.
//   Ports:
//     clk, rst                 in   clock, async active-high reset
//     frame_start              in   request one frame
//     player_x/y               in   5/4 player cell
//     bullet_x/y/active        in   5/4/1 bullet cell and valid
//     enemyN_x/y/active (0..2) in   5/4/1 enemy cells and valids
//     tile_valid/tile_ready    out/in handshake
//     tile_x/tile_y/tile_code  out  5/4/3 current tile
//     tile_last                out  final tile of frame
//     busy                     out  frame streaming
//     frame_done               out  pulse after last tile accepted
//     frame_count              out  8-bit completed-frame counter
//     overrun                  out  sticky: frame_start while busy
// Revision    : 1.0  initial release
// ============================================================================
module game_frame_serializer
    import game_pkg::*;
#(
    parameter int GRID_W = game_pkg::GRID_W,
    parameter int GRID_H = game_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [4:0] player_x,
    input  logic [3:0] player_y,
    input  logic [4:0] bullet_x,
    input  logic [3:0] bullet_y,
    input  logic       bullet_active,
    input  logic [4:0] enemy0_x,
    input  logic [3:0] enemy0_y,
    input  logic       enemy0_active,
    input  logic [4:0] enemy1_x,
    input  logic [3:0] enemy1_y,
    input  logic       enemy1_active,
    input  logic [4:0] enemy2_x,
    input  logic [3:0] enemy2_y,
    input  logic       enemy2_active,
    output logic       tile_valid,
    input  logic       tile_ready,
    output logic [4:0] tile_x,
    output logic [3:0] tile_y,
    output logic [2:0] tile_code,
    output logic       tile_last,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count,
    output logic       overrun
);

    localparam logic [4:0] c_COL_LAST = 5'(GRID_W - 1);
    localparam logic [3:0] c_ROW_LAST = 4'(GRID_H - 1);

    state_t     state_q,       state_d;
    logic [4:0] col_q,         col_d;
    logic [3:0] row_q,         row_d;
    snapshot_t  snap_q,        snap_d;
    logic       frame_done_q,  frame_done_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       overrun_q,     overrun_d;

    snapshot_t  w_live;
    logic [2:0] w_cls_code;
    logic       w_hs;
    logic       w_at_last;

    // Live game inputs gathered into snapshot layout for capture
    always_comb begin
        w_live                 = '0;
        w_live.player_x        = player_x;
        w_live.player_y        = player_y;
        w_live.bullet_x        = bullet_x;
        w_live.bullet_y        = bullet_y;
        w_live.bullet_active   = bullet_active;
        w_live.enemy_x[0]      = enemy0_x;
        w_live.enemy_y[0]      = enemy0_y;
        w_live.enemy_active[0] = enemy0_active;
        w_live.enemy_x[1]      = enemy1_x;
        w_live.enemy_y[1]      = enemy1_y;
        w_live.enemy_active[1] = enemy1_active;
        w_live.enemy_x[2]      = enemy2_x;
        w_live.enemy_y[2]      = enemy2_y;
        w_live.enemy_active[2] = enemy2_active;
    end

    tile_classifier #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_tile_classifier (
        .col       (col_q),
        .row       (row_q),
        .snap      (snap_q),
        .tile_code (w_cls_code)
    );

    assign w_hs      = tile_valid && tile_ready;
    assign w_at_last = (col_q == c_COL_LAST) && (row_q == c_ROW_LAST);

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        snap_d        = snap_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_d  = w_live;
                    col_d   = 5'd0;
                    row_d   = 4'd0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A request mid-frame cannot be honoured; flag it and keep going.
                if (frame_start) begin
                    overrun_d = 1'b1;
                end
                if (w_hs) begin
                    if (w_at_last) begin
                        state_d       = ST_IDLE;
                        col_d         = 5'd0;
                        row_d         = 4'd0;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end else if (col_q == c_COL_LAST) begin
                        col_d = 5'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            col_q         <= 5'd0;
            row_q         <= 4'd0;
            snap_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            snap_q        <= snap_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
        end
    end

    // Tile fields come straight from the scan counters and snapshot, so
    // they cannot move while a tile is stalled. Code/last are forced to
    // zero outside a frame: an all-zero snapshot would otherwise show the
    // player at (0,0).
    assign tile_valid  = (state_q == ST_STREAM);
    assign busy        = (state_q == ST_STREAM);
    assign tile_x      = col_q;
    assign tile_y      = row_q;
    assign tile_code   = tile_valid ? w_cls_code : TILE_EMPTY;
    assign tile_last   = tile_valid && w_at_last;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule : game_frame_serializer
`default_nettype wire

// File: tb/tb_game_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_frame_serializer
// Description : Directed self-checking bench for game_frame_serializer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_game_frame_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [4:0] player_x, bullet_x, enemy0_x, enemy1_x, enemy2_x;
    logic [3:0] player_y, bullet_y, enemy0_y, enemy1_y, enemy2_y;
    logic       bullet_active, enemy0_active, enemy1_active, enemy2_active;
    logic       tile_valid, tile_ready, tile_last, busy, frame_done, overrun;
    logic [4:0] tile_x;
    logic [3:0] tile_y;
    logic [2:0] tile_code;
    logic [7:0] frame_count;

    always #5 clk = ~clk;

    game_frame_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .player_x      (player_x),
        .player_y      (player_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .enemy0_x      (enemy0_x),
        .enemy0_y      (enemy0_y),
        .enemy0_active (enemy0_active),
        .enemy1_x      (enemy1_x),
        .enemy1_y      (enemy1_y),
        .enemy1_active (enemy1_active),
        .enemy2_x      (enemy2_x),
        .enemy2_y      (enemy2_y),
        .enemy2_active (enemy2_active),
        .tile_valid    (tile_valid),
        .tile_ready    (tile_ready),
        .tile_x        (tile_x),
        .tile_y        (tile_y),
        .tile_code     (tile_code),
        .tile_last     (tile_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .overrun       (overrun)
    );

    int total = 0;
    int bad   = 0;

    // Expected code per cell, index = row*20 + col, filled by hand per test
    logic [2:0] exp_map [0:299];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic set_objs(
        input logic [4:0] px,  input logic [3:0] py,
        input logic [4:0] bx,  input logic [3:0] by,  input logic ba,
        input logic [4:0] e0x, input logic [3:0] e0y, input logic e0a,
        input logic [4:0] e1x, input logic [3:0] e1y, input logic e1a,
        input logic [4:0] e2x, input logic [3:0] e2y, input logic e2a);
        player_x = px;  player_y = py;
        bullet_x = bx;  bullet_y = by;  bullet_active = ba;
        enemy0_x = e0x; enemy0_y = e0y; enemy0_active = e0a;
        enemy1_x = e1x; enemy1_y = e1y; enemy1_active = e1a;
        enemy2_x = e2x; enemy2_y = e2y; enemy2_active = e2a;
    endtask

    task automatic clear_map();
        for (int i = 0; i < 300; i++) exp_map[i] = 3'd0;
    endtask

    task automatic map_t1();
        clear_map();
        exp_map[14*20 + 10] = 3'd1;
        exp_map[5*20 + 10]  = 3'd3;
        exp_map[9*20 + 11]  = 3'd2;
    endtask

    task automatic objs_t1();
        set_objs(5'd10, 4'd14, 5'd11, 4'd9, 1'b1, 5'd10, 4'd5, 1'b1,
                 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    // Called at a negedge while idle; returns at the negedge after the
    // request has been sampled, where the first tile must be on offer.
    task automatic start_frame(input string tag);
        chk({tag, "_pre_valid"}, tile_valid, 0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({tag, "_latency_valid"}, tile_valid, 1);
        chk({tag, "_busy"}, busy, 1);
    endtask

    // ev_kind: 0 none, 1 change live inputs at tile ev_at,
    //          2 pulse frame_start at tile ev_at, 3 stop at tile ev_at
    task automatic stream(input string tag, input bit toggle, input int ev_at, input int ev_kind);
        int         n_acc   = 0;
        int         cyc     = 0;
        int         pi      = 0;
        bit         stalled = 1'b0;
        bit         fired   = 1'b0;
        bit         fs_clr  = 1'b0;
        logic [4:0] hx;
        logic [3:0] hy;
        logic [2:0] hc;
        logic       hl;
        logic       pat [0:3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        while (n_acc < 300 && cyc < 2000) begin
            if (ev_kind == 3 && n_acc == ev_at) break;
            if (fs_clr) begin
                frame_start = 1'b0;
                fs_clr      = 1'b0;
            end
            chk({tag, "_valid"}, tile_valid, 1);
            chk({tag, "_no_early_done"}, frame_done, 0);
            if (stalled) begin
                chk({tag, "_stall_x"}, tile_x, hx);
                chk({tag, "_stall_y"}, tile_y, hy);
                chk({tag, "_stall_code"}, tile_code, hc);
                chk({tag, "_stall_last"}, tile_last, hl);
            end
            tile_ready = toggle ? pat[pi % 4] : 1'b1;
            pi++;
            if (tile_ready) begin
                chk({tag, "_x"}, tile_x, n_acc % 20);
                chk({tag, "_y"}, tile_y, n_acc / 20);
                chk({tag, "_code"}, tile_code, exp_map[n_acc]);
                chk({tag, "_last"}, tile_last, (n_acc == 299) ? 1 : 0);
                n_acc++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hx = tile_x; hy = tile_y; hc = tile_code; hl = tile_last;
            end
            if (!fired && n_acc == ev_at && ev_kind == 1) begin
                fired = 1'b1;
                set_objs(5'd0, 4'd14, 5'd19, 4'd0, 1'b1, 5'd1, 4'd1, 1'b1,
                         5'd1, 4'd1, 1'b1, 5'd1, 4'd1, 1'b1);
            end
            if (!fired && n_acc == ev_at && ev_kind == 2) begin
                fired       = 1'b1;
                frame_start = 1'b1;
                fs_clr      = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        if (fs_clr) frame_start = 1'b0;
        if (ev_kind != 3) begin
            chk({tag, "_accepted"}, n_acc, 300);
            if (!toggle) chk({tag, "_cycles"}, cyc, 300);
        end else begin
            chk({tag, "_reached"}, n_acc, ev_at);
        end
    endtask

    // At the negedge right after the last handshake
    task automatic end_frame(input string tag, input int exp_cnt);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_end_valid"}, tile_valid, 0);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_count"}, frame_count, exp_cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, tile_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_x"}, tile_x, 0);
        chk({tag, "_y"}, tile_y, 0);
        chk({tag, "_code"}, tile_code, 0);
        chk({tag, "_last"}, tile_last, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_count"}, frame_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        tile_ready  = 1'b0;
        set_objs(5'd0, 4'd0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0,
                 5'd0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: player, lone enemy, lone bullet
        objs_t1();
        map_t1();
        start_frame("t1");
        stream("t1", 1'b0, -1, 0);
        end_frame("t1", 1);
        @(negedge clk);
        chk("t1_done_pulse", frame_done, 0);
        chk("t1_idle_valid", tile_valid, 0);

        // Hit cell, inactive enemy, off-field player, enemy on last tile
        set_objs(5'd31, 4'd15, 5'd10, 4'd5, 1'b1, 5'd10, 4'd5, 1'b1,
                 5'd3, 4'd3, 1'b0, 5'd19, 4'd14, 1'b1);
        clear_map();
        exp_map[5*20 + 10]  = 3'd4;
        exp_map[14*20 + 19] = 3'd3;
        start_frame("t2");
        stream("t2", 1'b0, -1, 0);
        end_frame("t2", 2);
        @(negedge clk);

        // Stalling ready pattern, live inputs changed mid-frame,
        // player outranks bullet+enemy on the same cell
        set_objs(5'd5, 4'd2, 5'd5, 4'd2, 1'b1, 5'd0, 4'd0, 1'b1,
                 5'd5, 4'd2, 1'b1, 5'd7, 4'd7, 1'b0);
        clear_map();
        exp_map[2*20 + 5] = 3'd1;
        exp_map[0]        = 3'd3;
        start_frame("t3");
        stream("t3", 1'b1, 150, 1);
        end_frame("t3", 3);
        @(negedge clk);

        // frame_start while streaming
        objs_t1();
        map_t1();
        start_frame("t4");
        chk("t4_overrun_pre", overrun, 0);
        stream("t4", 1'b0, 50, 2);
        chk("t4_overrun", overrun, 1);
        end_frame("t4", 4);
        @(negedge clk);
        chk("t4_single_done", frame_done, 0);
        chk("t4_no_restart", tile_valid, 0);
        chk("t4_overrun_sticky", overrun, 1);

        // Asynchronous reset mid-frame
        start_frame("t5");
        stream("t5", 1'b0, 120, 3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_stay_idle", tile_valid, 0);
        chk("t5_no_done", frame_done, 0);

        // 256 back-to-back frames; the first also shows the restart at (0,0)
        objs_t1();
        map_t1();
        for (int k = 0; k < 256; k++) begin
            start_frame("b2b");
            stream("b2b", 1'b0, -1, 0);
            end_frame("b2b", (k + 1) % 256);
        end
        chk("b2b_wrap", frame_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_game_frame_serializer
`default_nettype wire
